// File: rtl/sum_accumulator.sv
// Packet accumulator for the 12-bit adder sum stream: sums beats up to in_last
// with a saturating add and presents total, beat count and clip flag as one result.
module sum_accumulator #(
    parameter int IN_W  = 12,
    parameter int ACC_W = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             o_dbg_state
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high; the producer holds its payload stable until then, and ready never
    // depends on valid.

    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

    localparam int PAD = ACC_W + 1 - IN_W;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_sat;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sat_next;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // The extra top bit of the sum is the overflow flag; clamp to all-ones on it.
    assign w_sum      = {1'b0, r_acc} + {{PAD{1'b0}}, in_data};
    assign w_ovf      = w_sum[ACC_W];
    assign w_acc_next = w_ovf ? ACC_MAX : w_sum[ACC_W-1:0];
    assign w_sat_next = r_sat | w_ovf;
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC:  if (w_in_xfer && in_last) w_state_next = ST_OUT;
            ST_OUT:  if (w_out_xfer) w_state_next = ST_ACC;
            default: w_state_next = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        o_dbg_state = r_state;
        case (r_state)
            ST_ACC:  in_ready = ~rst;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_in_xfer) begin
            if (in_last) begin
                // Result includes this beat; the running state restarts for the next packet.
                r_out_data  <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_sat   <= w_sat_next;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sat       <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                r_sat <= w_sat_next;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a 20-bit and a 12-bit accumulator share one input
// stream and are checked against a whole-packet arithmetic model.
module tb_sum_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_sat, dbg_state;
    logic [19:0] out_data;
    logic [7:0]  out_count;
    logic        in_ready12, out_valid12, out_sat12, dbg_state12;
    logic [11:0] out_data12;
    logic [7:0]  out_count12;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cnt_q[$];

    sum_accumulator #(.IN_W(12), .ACC_W(20), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .out_sat(out_sat), .o_dbg_state(dbg_state)
    );

    sum_accumulator #(.IN_W(12), .ACC_W(12), .CNT_W(8)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid12),
        .out_ready(out_ready), .out_data(out_data12), .out_count(out_count12),
        .out_sat(out_sat12), .o_dbg_state(dbg_state12)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [11:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout in_ready stuck low, got=0 exp=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 20'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%0b exp=0", out_sat); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_beat(12'd100, 1'b0);
        send_beat(12'd200, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
        send_beat(12'd4095, 1'b1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 20'd4395) begin failures++; $display("FAIL basic_data got=%0d exp=4395", out_data); end
        checks++; if (out_count !== 8'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", out_count); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%0b exp=0", out_sat); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        send_beat(12'd7, 1'b1);
        checks++; if (out_data !== 20'd7) begin failures++; $display("FAIL single_data got=%0d exp=7", out_data); end
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", out_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_in_ready got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_sat12();
        out_ready = 1'b1;
        send_beat(12'd4000, 1'b0);
        send_beat(12'd200, 1'b1);
        checks++; if (out_data12 !== 12'd4095) begin failures++; $display("FAIL sat12_data got=%0d exp=4095", out_data12); end
        checks++; if (out_sat12 !== 1'b1) begin failures++; $display("FAIL sat12_flag got=%0b exp=1", out_sat12); end
        checks++; if (out_data !== 20'd4200 || out_sat !== 1'b0) begin failures++; $display("FAIL sat20_data got=%0d/%0b exp=4200/0", out_data, out_sat); end
        send_beat(12'd5, 1'b1);
        checks++; if (out_data12 !== 12'd5) begin failures++; $display("FAIL sat12_next_data got=%0d exp=5", out_data12); end
        checks++; if (out_sat12 !== 1'b0) begin failures++; $display("FAIL sat12_sticky_clear got=%0b exp=0", out_sat12); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(12'd11, 1'b0);
        send_beat(12'd22, 1'b1);
        in_valid = 1'b1; in_data = 12'd33; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 20'd33 || out_count !== 8'd2) begin
                failures++; $display("FAIL bp_hold cycle=%0d got=%0b/%0d/%0d exp=1/33/2", i, out_valid, out_data, out_count);
            end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=%0b/%0b exp=0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 20'd33 || out_count !== 8'd1) begin
            failures++; $display("FAIL bp_resume got=%0b/%0d/%0d exp=1/33/1", out_valid, out_data, out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_beat(12'd50, 1'b0);
        send_beat(12'd60, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_beat(12'd9, 1'b1);
        checks++; if (out_data !== 20'd9 || out_count !== 8'd1) begin
            failures++; $display("FAIL rstmid_data got=%0d/%0d exp=9/1", out_data, out_count);
        end
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(12'd3, 1'b1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstout_pending got=%0b exp=1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 20'd0) begin
            failures++; $display("FAIL rstout_drop got=%0b/%0d exp=0/0", out_valid, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int  n_pk = 150;
        int  got = 0;
        int  cyc = 0;
        bit  drv_done = 0;
        bit  abort = 0;
        fork
            begin : driver
                for (int p = 0; p < n_pk && !abort; p++) begin
                    int          len, mode, wait_cyc;
                    logic [31:0] tot;
                    logic [11:0] d;
                    bit          acc;
                    len  = (p % 25 == 24) ? $urandom_range(256, 300) : $urandom_range(1, 40);
                    mode = $urandom_range(0, 3);
                    tot  = 0;
                    for (int b = 0; b < len && !abort; b++) begin
                        case (mode)
                            0:       d = 12'hFFF;
                            1:       d = 12'd0;
                            default: d = 12'($urandom_range(0, 4095));
                        endcase
                        acc = 1'b0;
                        wait_cyc = 0;
                        while (!acc && !abort) begin
                            in_valid = ($urandom_range(0, 3) != 0);
                            in_data  = d;
                            in_last  = (b == len - 1);
                            if (in_valid && in_ready) begin
                                acc = 1'b1;
                                tot = tot + 32'(d);
                                if (b == len - 1) begin
                                    exp_q.push_back(tot);
                                    cnt_q.push_back(32'(len));
                                end
                            end
                            wait_cyc++;
                            if (wait_cyc > 500) abort = 1'b1;
                            @(negedge clk);
                        end
                    end
                end
                in_valid = 1'b0; in_last = 1'b0;
                drv_done = 1'b1;
            end
            begin : monitor
                while (got < n_pk && cyc < 40000 && !abort) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rand_unexpected result got=%0d exp=none", out_data);
                        end else begin
                            logic [31:0] t, n, e20, e12, ec;
                            t   = exp_q.pop_front();
                            n   = cnt_q.pop_front();
                            e20 = (t > 32'hFFFFF) ? 32'hFFFFF : t;
                            e12 = (t > 32'hFFF) ? 32'hFFF : t;
                            ec  = (n > 255) ? 32'd255 : n;
                            checks++; if (32'(out_data) !== e20) begin failures++; $display("FAIL rand_data20 pkt=%0d got=%0d exp=%0d", got, out_data, e20); end
                            checks++; if (out_sat !== (t > 32'hFFFFF)) begin failures++; $display("FAIL rand_sat20 pkt=%0d got=%0b exp=%0b", got, out_sat, t > 32'hFFFFF); end
                            checks++; if (32'(out_count) !== ec) begin failures++; $display("FAIL rand_count pkt=%0d got=%0d exp=%0d", got, out_count, ec); end
                            checks++; if (32'(out_data12) !== e12) begin failures++; $display("FAIL rand_data12 pkt=%0d got=%0d exp=%0d", got, out_data12, e12); end
                            checks++; if (out_sat12 !== (t > 32'hFFF)) begin failures++; $display("FAIL rand_sat12 pkt=%0d got=%0b exp=%0b", got, out_sat12, t > 32'hFFF); end
                            checks++; if (out_count12 !== out_count || out_valid12 !== 1'b1) begin failures++; $display("FAIL rand_lockstep pkt=%0d got=%0d/%0b exp=%0d/1", got, out_count12, out_valid12, out_count); end
                        end
                        got++;
                    end
                    cyc++;
                    @(negedge clk);
                end
                abort = 1'b1;
            end
        join
        out_ready = 1'b0;
        checks++; if (got != n_pk) begin failures++; $display("FAIL rand_packets got=%0d exp=%0d", got, n_pk); end
        checks++; if (!drv_done || exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_single();
        test_sat12();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
